// File: rtl/ascon_pack.sv
// Shared types and round constants for the ASCON permutation round sequencer.
package ascon_pack;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} round_state_t;
   typedef enum logic {PERM_A, PERM_B} perm_mode_t;

   localparam int ROUND_START_A = 0;
   localparam int ROUND_START_B = 6;
   localparam int ROUND_LAST    = 11;

endpackage

// File: rtl/ascon_round_index_cnt.sv
// Round index register: load one of two start values or increment, all gated by en.
module ascon_round_index_cnt #(
   parameter int                  ROUND_W = 4,
   parameter logic [ROUND_W-1:0]  START_A = '0,
   parameter logic [ROUND_W-1:0]  START_B = ROUND_W'(6)
) (
   input  logic               clock_i,
   input  logic               resetb_i,
   input  logic               en,
   input  logic               load_a,
   input  logic               load_b,
   input  logic               inc,
   output logic [ROUND_W-1:0] count
);

   // load_a wins over load_b so a clear (abort) can never be masked by a load.
   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         count <= '0;
      end else if (en) begin
         if (load_a) begin
            count <= START_A;
         end else if (load_b) begin
            count <= START_B;
         end else if (inc) begin
            count <= count + 1'b1;
         end
      end
   end

endmodule

// File: rtl/ascon_round_ctrl.sv
// Round sequencer for the ASCON-128 permutation: runs p^a (12 rounds) or p^b (6 rounds).
// Handshake: start_i is taken only on an edge where ready_o=1 and abort_i=0; done_o pulses once per completed run.
module ascon_round_ctrl
   import ascon_pack::*;
#(
   parameter int ROUNDS_A = ROUND_LAST + 1,
   parameter int ROUNDS_B = ROUND_LAST + 1 - ROUND_START_B,
   parameter int ROUND_W  = 4
) (
   input  logic               clock_i,
   input  logic               resetb_i,
   input  logic               start_i,
   input  logic               mode_i,
   input  logic               abort_i,
   output logic               ready_o,
   output logic               busy_o,
   output logic               perm_en_o,
   output logic               first_round_o,
   output logic               last_round_o,
   output logic [ROUND_W-1:0] round_o,
   output logic               done_o,
   output round_state_t       dbg_state
);

   if (!(ROUNDS_B <= ROUNDS_A && ROUNDS_A <= 2**ROUND_W)) begin : g_bad_rounds
      $error("ascon_round_ctrl: need ROUNDS_B <= ROUNDS_A <= 2**ROUND_W");
   end

   localparam logic [ROUND_W-1:0] START_A = ROUND_W'(ROUND_START_A);
   localparam logic [ROUND_W-1:0] START_B = ROUND_W'(ROUNDS_A - ROUNDS_B);
   localparam logic [ROUND_W-1:0] LAST    = ROUND_W'(ROUNDS_A - 1);

   round_state_t state, state_next;
   logic         first, first_next;
   logic         cnt_en, load_a, load_b, inc;
   logic [ROUND_W-1:0] round;

   ascon_round_index_cnt #(
      .ROUND_W (ROUND_W),
      .START_A (START_A),
      .START_B (START_B)
   ) u_cnt (
      .clock_i  (clock_i),
      .resetb_i (resetb_i),
      .en       (cnt_en),
      .load_a   (load_a),
      .load_b   (load_b),
      .inc      (inc),
      .count    (round)
   );

   always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) begin
         state <= ST_IDLE;
         first <= 1'b0;
      end else begin
         state <= state_next;
         first <= first_next;
      end
   end

   // Abort reuses the load_a path (start value 0) to clear the round index.
   always_comb begin
      state_next = state;
      first_next = 1'b0;
      cnt_en     = 1'b0;
      load_a     = 1'b0;
      load_b     = 1'b0;
      inc        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (abort_i) begin
               cnt_en = 1'b1;
               load_a = 1'b1;
            end else if (start_i) begin
               state_next = ST_RUN;
               first_next = 1'b1;
               cnt_en     = 1'b1;
               if (perm_mode_t'(mode_i) == PERM_B) begin
                  load_b = 1'b1;
               end else begin
                  load_a = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (abort_i) begin
               state_next = ST_IDLE;
               cnt_en     = 1'b1;
               load_a     = 1'b1;
            end else if (round == LAST) begin
               state_next = ST_DONE;
            end else begin
               cnt_en = 1'b1;
               inc    = 1'b1;
            end
         end
         ST_DONE: begin
            state_next = ST_IDLE;
            if (abort_i) begin
               cnt_en = 1'b1;
               load_a = 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   assign ready_o       = (state == ST_IDLE);
   assign busy_o        = (state == ST_RUN);
   assign perm_en_o     = (state == ST_RUN);
   assign first_round_o = first && (state == ST_RUN);
   assign last_round_o  = (state == ST_RUN) && (round == LAST);
   assign done_o        = (state == ST_DONE);
   assign round_o       = round;
   assign dbg_state     = state;

endmodule

// File: tb/tb_ascon_round_ctrl.sv
// Self-checking bench for ascon_round_ctrl: cycle table plus p^a/p^b, abort and reset sequences.
module tb_ascon_round_ctrl;
   import ascon_pack::*;

   logic         clock_i  = 1'b0;
   logic         resetb_i = 1'b0;
   logic         start_i  = 1'b0;
   logic         mode_i   = 1'b0;
   logic         abort_i  = 1'b0;
   logic         ready_o, busy_o, perm_en_o, first_round_o, last_round_o, done_o;
   logic [3:0]   round_o;
   round_state_t dbg_state;

   ascon_round_ctrl dut (
      .clock_i       (clock_i),
      .resetb_i      (resetb_i),
      .start_i       (start_i),
      .mode_i        (mode_i),
      .abort_i       (abort_i),
      .ready_o       (ready_o),
      .busy_o        (busy_o),
      .perm_en_o     (perm_en_o),
      .first_round_o (first_round_o),
      .last_round_o  (last_round_o),
      .round_o       (round_o),
      .done_o        (done_o),
      .dbg_state     (dbg_state)
   );

   always #5 clock_i = ~clock_i;

   // Output vector layout: {ready, busy, perm_en, first, last, done, round[3:0]}
   typedef struct {
      logic       start;
      logic       mode;
      logic       abort;
      logic [9:0] exp;
   } vec_t;

   logic [9:0] exp_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   vec_t       tbl [14];

   function automatic logic [9:0] idle_v(input logic [3:0] r);
      return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, r};
   endfunction

   function automatic logic [9:0] run_v(input logic [3:0] r, input logic f, input logic l);
      return {1'b0, 1'b1, 1'b1, f, l, 1'b0, r};
   endfunction

   function automatic logic [9:0] done_v();
      return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd11};
   endfunction

   task automatic check(input string name, input logic [9:0] exp);
      logic [9:0] act;
      act = {ready_o, busy_o, perm_en_o, first_round_o, last_round_o, done_o, round_o};
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b required %b (rdy,bsy,en,first,last,done,round)", name, act, exp);
      end
   endtask

   task automatic check_state(input string name, input round_state_t exp);
      n_cmp++;
      if (dbg_state !== exp) begin
         n_bad++;
         $display("FAIL %s: state got %0d required %0d", name, dbg_state, exp);
      end
   endtask

   // Inputs change at the falling edge; outputs are sampled at the next falling edge.
   task automatic drive_cycle(input string name, input logic s, input logic m, input logic a);
      start_i = s;
      mode_i  = m;
      abort_i = a;
      @(posedge clock_i);
      @(negedge clock_i);
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: scoreboard empty, nothing expected", name);
      end else begin
         check(name, exp_q.pop_front());
      end
   endtask

   task automatic do_perm(input logic m, input logic noisy);
      int         n;
      logic [3:0] s0;
      logic       s, md;
      n  = m ? 6 : 12;
      s0 = m ? 4'd6 : 4'd0;
      for (int k = 0; k < n; k++) exp_q.push_back(run_v(s0 + 4'(k), k == 0, k == n - 1));
      exp_q.push_back(done_v());
      exp_q.push_back(idle_v(4'd11));
      for (int k = 0; k <= n + 1; k++) begin
         if (k == 0) begin
            s  = 1'b1;
            md = m;
         end else begin
            s  = noisy && ((k == n + 1) || ($urandom_range(0, 1) == 1));
            md = 1'($urandom_range(0, 1));
         end
         drive_cycle(m ? "perm_b" : "perm_a", s, md, 1'b0);
      end
      start_i = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{1'b0, 1'b0, 1'b0, idle_v(4'd0)};
      tbl[1]  = '{1'b1, 1'b0, 1'b1, idle_v(4'd0)};
      tbl[2]  = '{1'b0, 1'b1, 1'b0, idle_v(4'd0)};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, run_v(4'd6, 1'b1, 1'b0)};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, run_v(4'd7, 1'b0, 1'b0)};
      tbl[5]  = '{1'b1, 1'b0, 1'b0, run_v(4'd8, 1'b0, 1'b0)};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, run_v(4'd9, 1'b0, 1'b0)};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, run_v(4'd10, 1'b0, 1'b0)};
      tbl[8]  = '{1'b0, 1'b0, 1'b0, run_v(4'd11, 1'b0, 1'b1)};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, done_v()};
      tbl[10] = '{1'b1, 1'b0, 1'b0, idle_v(4'd11)};
      tbl[11] = '{1'b0, 1'b0, 1'b0, idle_v(4'd11)};
      tbl[12] = '{1'b0, 1'b0, 1'b1, idle_v(4'd0)};
      tbl[13] = '{1'b0, 1'b0, 1'b0, idle_v(4'd0)};

      // Reset held, then released with five idle cycles.
      repeat (2) @(negedge clock_i);
      check("reset_hold", idle_v(4'd0));
      check_state("reset_hold_state", ST_IDLE);
      resetb_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(idle_v(4'd0));
         drive_cycle("idle_after_reset", 1'b0, 1'b0, 1'b0);
      end

      // Cycle table: idle, abort+start priority, p^b with ignored starts, abort in idle.
      for (int i = 0; i < 14; i++) begin
         exp_q.push_back(tbl[i].exp);
         drive_cycle($sformatf("table[%0d]", i), tbl[i].start, tbl[i].mode, tbl[i].abort);
      end

      do_perm(1'b0, 1'b0);
      do_perm(1'b0, 1'b1);
      do_perm(1'b1, 1'b1);

      // Abort at round 4 of p^a, then abort+start together in idle.
      for (int k = 0; k < 5; k++) exp_q.push_back(run_v(4'(k), k == 0, 1'b0));
      for (int k = 0; k < 4; k++) exp_q.push_back(idle_v(4'd0));
      drive_cycle("abort_seq", 1'b1, 1'b0, 1'b0);
      for (int k = 1; k < 5; k++) drive_cycle("abort_seq", 1'b0, 1'b0, 1'b0);
      drive_cycle("abort_at_r4", 1'b0, 1'b0, 1'b1);
      drive_cycle("abort_start_idle", 1'b1, 1'b0, 1'b1);
      drive_cycle("after_abort", 1'b0, 1'b0, 1'b0);
      drive_cycle("after_abort", 1'b0, 1'b0, 1'b0);

      // Asynchronous reset in the middle of p^b.
      exp_q.push_back(run_v(4'd6, 1'b1, 1'b0));
      exp_q.push_back(run_v(4'd7, 1'b0, 1'b0));
      exp_q.push_back(run_v(4'd8, 1'b0, 1'b0));
      drive_cycle("pre_reset_pb", 1'b1, 1'b1, 1'b0);
      drive_cycle("pre_reset_pb", 1'b0, 1'b0, 1'b0);
      drive_cycle("pre_reset_pb", 1'b0, 1'b0, 1'b0);
      #2 resetb_i = 1'b0;
      #1 check("async_reset", idle_v(4'd0));
      check_state("async_reset_state", ST_IDLE);
      @(posedge clock_i);
      @(negedge clock_i);
      check("reset_held_edge", idle_v(4'd0));
      resetb_i = 1'b1;
      exp_q.push_back(idle_v(4'd0));
      drive_cycle("post_reset_idle", 1'b0, 1'b0, 1'b0);

      do_perm(1'b1, 1'b0);
      do_perm(1'b0, 1'b0);

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
